// File: rtl/pipeline_sequencer_pkg.sv
// Shared definitions for pipeline_sequencer: FSM state codes, forwarding selects,
// the R15 index and the per-cycle stage-control bundle with its hazard evaluation.
package pipeline_sequencer_pkg;

  localparam int unsigned MAX_REG_W = 16;
  // R15 is the all-ones index; users slice the low REG_W bits for their width.
  localparam logic [MAX_REG_W-1:0] R15_IDX = '1;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_EX  = 2'b01,
    FWD_MEM = 2'b10,
    FWD_WB  = 2'b11
  } fwd_sel_e;

  typedef enum logic [1:0] {
    S_RUN        = 2'b00,
    S_LOAD_STALL = 2'b01,
    S_MEM_WAIT   = 2'b10,
    S_FLUSH      = 2'b11
  } seq_state_e;

  typedef struct packed {
    seq_state_e next_state;
    logic       pc_ld;
    logic       ifid_ld;
    logic       idex_ld;
    logic       exmem_ld;
    logic       memwb_ld;
    logic       ifid_flush;
    logic       idex_bubble;
  } seq_ctrl_t;

  localparam seq_ctrl_t CTRL_ADVANCE = '{next_state: S_RUN, pc_ld: 1'b1, ifid_ld: 1'b1,
    idex_ld: 1'b1, exmem_ld: 1'b1, memwb_ld: 1'b1, ifid_flush: 1'b0, idex_bubble: 1'b0};
  localparam seq_ctrl_t CTRL_HOLD = '{next_state: S_MEM_WAIT, pc_ld: 1'b0, ifid_ld: 1'b0,
    idex_ld: 1'b0, exmem_ld: 1'b0, memwb_ld: 1'b0, ifid_flush: 1'b0, idex_bubble: 1'b0};
  localparam seq_ctrl_t CTRL_BRANCH = '{next_state: S_FLUSH, pc_ld: 1'b1, ifid_ld: 1'b1,
    idex_ld: 1'b1, exmem_ld: 1'b1, memwb_ld: 1'b1, ifid_flush: 1'b1, idex_bubble: 1'b1};
  localparam seq_ctrl_t CTRL_LOAD_STALL = '{next_state: S_LOAD_STALL, pc_ld: 1'b0,
    ifid_ld: 1'b0, idex_ld: 1'b1, exmem_ld: 1'b1, memwb_ld: 1'b1, ifid_flush: 1'b0,
    idex_bubble: 1'b1};
  localparam seq_ctrl_t CTRL_FLUSH = '{next_state: S_RUN, pc_ld: 1'b1, ifid_ld: 1'b1,
    idex_ld: 1'b1, exmem_ld: 1'b1, memwb_ld: 1'b1, ifid_flush: 1'b0, idex_bubble: 1'b1};
  localparam seq_ctrl_t CTRL_RESET = '{next_state: S_RUN, pc_ld: 1'b1, ifid_ld: 1'b1,
    idex_ld: 1'b1, exmem_ld: 1'b1, memwb_ld: 1'b1, ifid_flush: 1'b1, idex_bubble: 1'b1};

  // Hazard priority applied whenever the sequencer evaluates as if in RUN.
  function automatic seq_ctrl_t run_eval(input logic mem_busy,
                                         input logic branch_taken,
                                         input logic load_use);
    seq_ctrl_t c;
    if (mem_busy)          c = CTRL_HOLD;
    else if (branch_taken) c = CTRL_BRANCH;
    else if (load_use)     c = CTRL_LOAD_STALL;
    else                   c = CTRL_ADVANCE;
    return c;
  endfunction

endpackage

// File: rtl/pipeline_sequencer_forward_select.sv
// Operand bypass select: picks the youngest live writer (EX > MEM > WB) of one ID source.
module forward_select
  import pipeline_sequencer_pkg::*;
#(
  parameter int REG_W = 4
) (
  input  logic [REG_W-1:0] src_idx,
  input  logic             src_use,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_rf_we,
  input  logic [REG_W-1:0] mem_rd,
  input  logic             mem_rf_we,
  input  logic [REG_W-1:0] wb_rd,
  input  logic             wb_rf_we,
  output logic [1:0]       fwd_sel
);

  localparam logic [REG_W-1:0] R15 = R15_IDX[REG_W-1:0];

  // R15 reads are never bypassed, even when a stage targets it.
  logic live;
  assign live = src_use && (src_idx != R15);

  // NOTE: assign a default first in every always_comb so no path leaves the output
  // unassigned; a missing default silently infers a latch.
  always_comb begin
    fwd_sel = FWD_RF;
    if (live && ex_rf_we && (ex_rd == src_idx))        fwd_sel = FWD_EX;
    else if (live && mem_rf_we && (mem_rd == src_idx)) fwd_sel = FWD_MEM;
    else if (live && wb_rf_we && (wb_rd == src_idx))   fwd_sel = FWD_WB;
  end

endmodule

// File: rtl/pipeline_sequencer.sv
// Pipeline hazard sequencer: operand forwarding plus stall/flush FSM for a 5-stage pipe.
// Optional macro PIPELINE_SEQ_PERF_EN adds a saturating 16-bit stall_count output.
module pipeline_sequencer
  import pipeline_sequencer_pkg::*;
#(
  parameter int REG_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] id_rn,
  input  logic [REG_W-1:0] id_rm,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_use_rn,
  input  logic             id_use_rm,
  input  logic             id_use_rd,
  input  logic [REG_W-1:0] ex_rd,
  input  logic [REG_W-1:0] mem_rd,
  input  logic [REG_W-1:0] wb_rd,
  input  logic             ex_rf_we,
  input  logic             mem_rf_we,
  input  logic             wb_rf_we,
  input  logic             ex_is_load,
  input  logic             ex_branch_taken,
  input  logic             mem_busy,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [1:0]       fwd_c,
  output logic             pc_ld,
  output logic             ifid_ld,
  output logic             idex_ld,
  output logic             exmem_ld,
  output logic             memwb_ld,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic [1:0]       seq_state
`ifdef PIPELINE_SEQ_PERF_EN
  ,
  output logic [15:0]      stall_count
`endif
);

  localparam logic [REG_W-1:0] R15 = R15_IDX[REG_W-1:0];

  seq_state_e state;
  seq_ctrl_t  ctrl;
  logic [1:0] fwd_a_raw, fwd_b_raw, fwd_c_raw;
  logic       load_use;

  forward_select #(.REG_W(REG_W)) u_fwd_a (
    .src_idx(id_rn), .src_use(id_use_rn),
    .ex_rd(ex_rd), .ex_rf_we(ex_rf_we), .mem_rd(mem_rd), .mem_rf_we(mem_rf_we),
    .wb_rd(wb_rd), .wb_rf_we(wb_rf_we), .fwd_sel(fwd_a_raw)
  );

  forward_select #(.REG_W(REG_W)) u_fwd_b (
    .src_idx(id_rm), .src_use(id_use_rm),
    .ex_rd(ex_rd), .ex_rf_we(ex_rf_we), .mem_rd(mem_rd), .mem_rf_we(mem_rf_we),
    .wb_rd(wb_rd), .wb_rf_we(wb_rf_we), .fwd_sel(fwd_b_raw)
  );

  forward_select #(.REG_W(REG_W)) u_fwd_c (
    .src_idx(id_rd), .src_use(id_use_rd),
    .ex_rd(ex_rd), .ex_rf_we(ex_rf_we), .mem_rd(mem_rd), .mem_rf_we(mem_rf_we),
    .wb_rd(wb_rd), .wb_rf_we(wb_rf_we), .fwd_sel(fwd_c_raw)
  );

  function automatic logic src_hit(input logic [REG_W-1:0] idx, input logic use_flag,
                                   input logic [REG_W-1:0] dst);
    return use_flag && (idx == dst) && (idx != R15);
  endfunction

  assign load_use = ex_is_load && ex_rf_we &&
                    (src_hit(id_rn, id_use_rn, ex_rd) ||
                     src_hit(id_rm, id_use_rm, ex_rd) ||
                     src_hit(id_rd, id_use_rd, ex_rd));

  always_comb begin
    ctrl = CTRL_ADVANCE;
    unique case (state)
      // The bubble is already in EX; ignoring load-use here avoids stalling twice on one load.
      S_LOAD_STALL: ctrl = run_eval(mem_busy, ex_branch_taken, 1'b0);
      S_FLUSH:      ctrl = mem_busy ? CTRL_HOLD : CTRL_FLUSH;
      default:      ctrl = run_eval(mem_busy, ex_branch_taken, load_use);
    endcase
    if (reset) ctrl = CTRL_RESET;
  end

  // NOTE: registered state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation races.
  always_ff @(posedge clk) begin
    if (reset) state <= S_RUN;
    else       state <= ctrl.next_state;
  end

  assign pc_ld       = ctrl.pc_ld;
  assign ifid_ld     = ctrl.ifid_ld;
  assign idex_ld     = ctrl.idex_ld;
  assign exmem_ld    = ctrl.exmem_ld;
  assign memwb_ld    = ctrl.memwb_ld;
  assign ifid_flush  = ctrl.ifid_flush;
  assign idex_bubble = ctrl.idex_bubble;
  assign seq_state   = reset ? S_RUN : state;
  assign fwd_a       = reset ? FWD_RF : fwd_a_raw;
  assign fwd_b       = reset ? FWD_RF : fwd_b_raw;
  assign fwd_c       = reset ? FWD_RF : fwd_c_raw;

`ifdef PIPELINE_SEQ_PERF_EN
  always_ff @(posedge clk) begin
    if (reset)
      stall_count <= '0;
    else if (!ctrl.pc_ld && (stall_count != 16'hFFFF))
      stall_count <= stall_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Directed self-checking bench for pipeline_sequencer; inputs change on the falling
// edge and outputs are sampled 1 time unit later, well clear of the rising edge.
module tb_pipeline_sequencer;

  localparam int REG_W = 4;
  // {pc_ld, ifid_ld, idex_ld, exmem_ld, memwb_ld, ifid_flush, idex_bubble}
  localparam logic [6:0] C_RUN    = 7'b11111_00;
  localparam logic [6:0] C_HOLD   = 7'b00000_00;
  localparam logic [6:0] C_BRANCH = 7'b11111_11;
  localparam logic [6:0] C_LSTALL = 7'b00111_01;
  localparam logic [6:0] C_FLUSH  = 7'b11111_01;
  localparam logic [6:0] C_RESET  = 7'b11111_11;

  logic clk, reset;
  logic [REG_W-1:0] id_rn, id_rm, id_rd, ex_rd, mem_rd, wb_rd;
  logic id_use_rn, id_use_rm, id_use_rd, ex_rf_we, mem_rf_we, wb_rf_we;
  logic ex_is_load, ex_branch_taken, mem_busy;
  logic [1:0] fwd_a, fwd_b, fwd_c, seq_state;
  logic pc_ld, ifid_ld, idex_ld, exmem_ld, memwb_ld, ifid_flush, idex_bubble;
  logic [6:0] ctl;
`ifdef PIPELINE_SEQ_PERF_EN
  logic [15:0] stall_count;
`endif

  int errors = 0;
  int checks = 0;

  pipeline_sequencer #(.REG_W(REG_W)) dut (
    .clk(clk), .reset(reset),
    .id_rn(id_rn), .id_rm(id_rm), .id_rd(id_rd),
    .id_use_rn(id_use_rn), .id_use_rm(id_use_rm), .id_use_rd(id_use_rd),
    .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd),
    .ex_rf_we(ex_rf_we), .mem_rf_we(mem_rf_we), .wb_rf_we(wb_rf_we),
    .ex_is_load(ex_is_load), .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .fwd_c(fwd_c),
    .pc_ld(pc_ld), .ifid_ld(ifid_ld), .idex_ld(idex_ld), .exmem_ld(exmem_ld),
    .memwb_ld(memwb_ld), .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
    .seq_state(seq_state)
`ifdef PIPELINE_SEQ_PERF_EN
    , .stall_count(stall_count)
`endif
  );

  assign ctl = {pc_ld, ifid_ld, idex_ld, exmem_ld, memwb_ld, ifid_flush, idex_bubble};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_inputs();
    id_rn = '0; id_rm = '0; id_rd = '0; ex_rd = '0; mem_rd = '0; wb_rd = '0;
    id_use_rn = 0; id_use_rm = 0; id_use_rd = 0;
    ex_rf_we = 0; mem_rf_we = 0; wb_rf_we = 0;
    ex_is_load = 0; ex_branch_taken = 0; mem_busy = 0;
  endtask

  // Starts a cycle: waits for the falling edge; caller sets inputs then calls settle().
  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic test_reset();
    next_cycle();
    clear_inputs();
    reset = 1; mem_busy = 1;
    ex_rf_we = 1; ex_rd = 4'd3; id_rn = 4'd3; id_use_rn = 1;
    settle();
    checks++; if (ctl !== C_RESET) begin errors++; $display("FAIL reset_ctl: got %b want %b", ctl, C_RESET); end
    checks++; if (seq_state !== 2'b00) begin errors++; $display("FAIL reset_state: got %b want 00", seq_state); end
    checks++; if (fwd_a !== 2'b00) begin errors++; $display("FAIL reset_fwd_a: got %b want 00", fwd_a); end
    next_cycle();
    clear_inputs(); reset = 0;
    settle();
    checks++; if (seq_state !== 2'b00) begin errors++; $display("FAIL post_reset_state: got %b want 00", seq_state); end
    checks++; if (ctl !== C_RUN) begin errors++; $display("FAIL post_reset_ctl: got %b want %b", ctl, C_RUN); end
  endtask

  task automatic test_forward_ex();
    next_cycle();
    clear_inputs();
    ex_rf_we = 1; ex_rd = 4'd3; id_rn = 4'd3; id_use_rn = 1; id_rm = 4'd3;
    settle();
    checks++; if (fwd_a !== 2'b01) begin errors++; $display("FAIL fwd_ex_a: got %b want 01", fwd_a); end
    checks++; if (fwd_b !== 2'b00) begin errors++; $display("FAIL fwd_ex_b_unused: got %b want 00", fwd_b); end
    checks++; if (ctl !== C_RUN) begin errors++; $display("FAIL fwd_ex_ctl: got %b want %b", ctl, C_RUN); end
  endtask

  task automatic test_forward_priority();
    next_cycle();
    clear_inputs();
    id_rd = 4'd7; id_use_rd = 1;
    ex_rd = 4'd7; mem_rd = 4'd7; wb_rd = 4'd7;
    ex_rf_we = 1; mem_rf_we = 1; wb_rf_we = 1;
    settle();
    checks++; if (fwd_c !== 2'b01) begin errors++; $display("FAIL prio_ex: got %b want 01", fwd_c); end
    ex_rf_we = 0; settle();
    checks++; if (fwd_c !== 2'b10) begin errors++; $display("FAIL prio_mem: got %b want 10", fwd_c); end
    mem_rf_we = 0; settle();
    checks++; if (fwd_c !== 2'b11) begin errors++; $display("FAIL prio_wb: got %b want 11", fwd_c); end
    wb_rd = 4'd6; settle();
    checks++; if (fwd_c !== 2'b00) begin errors++; $display("FAIL prio_idx_miss: got %b want 00", fwd_c); end
    wb_rd = 4'd7; id_use_rd = 0; settle();
    checks++; if (fwd_c !== 2'b00) begin errors++; $display("FAIL prio_use_off: got %b want 00", fwd_c); end
    id_rm = 4'd2; id_use_rm = 1; mem_rd = 4'd2; mem_rf_we = 1; settle();
    checks++; if (fwd_b !== 2'b10) begin errors++; $display("FAIL prio_b_mem: got %b want 10", fwd_b); end
  endtask

  task automatic test_r15();
    next_cycle();
    clear_inputs();
    id_rn = 4'd15; id_use_rn = 1;
    ex_rd = 4'd15; mem_rd = 4'd15; wb_rd = 4'd15;
    ex_rf_we = 1; mem_rf_we = 1; wb_rf_we = 1; ex_is_load = 1;
    settle();
    checks++; if (fwd_a !== 2'b00) begin errors++; $display("FAIL r15_fwd_a: got %b want 00", fwd_a); end
    checks++; if (ctl !== C_RUN) begin errors++; $display("FAIL r15_no_load_stall: got %b want %b", ctl, C_RUN); end
  endtask

  task automatic test_load_use();
    next_cycle();
    clear_inputs();
    ex_is_load = 1; ex_rf_we = 1; ex_rd = 4'd5; id_rm = 4'd5; id_use_rm = 1;
    settle();
    checks++; if (ctl !== C_LSTALL) begin errors++; $display("FAIL lu_stall_ctl: got %b want %b", ctl, C_LSTALL); end
    checks++; if (seq_state !== 2'b00) begin errors++; $display("FAIL lu_detect_state: got %b want 00", seq_state); end
    next_cycle();
    clear_inputs();
    id_rm = 4'd5; id_use_rm = 1; mem_rd = 4'd5; mem_rf_we = 1;
    settle();
    checks++; if (seq_state !== 2'b01) begin errors++; $display("FAIL lu_stall_state: got %b want 01", seq_state); end
    checks++; if (fwd_b !== 2'b10) begin errors++; $display("FAIL lu_fwd_b_mem: got %b want 10", fwd_b); end
    checks++; if (ctl !== C_RUN) begin errors++; $display("FAIL lu_release_ctl: got %b want %b", ctl, C_RUN); end
    next_cycle();
    clear_inputs();
    settle();
    checks++; if (seq_state !== 2'b00) begin errors++; $display("FAIL lu_back_to_run: got %b want 00", seq_state); end
  endtask

  task automatic test_no_double_stall();
    next_cycle();
    clear_inputs();
    ex_is_load = 1; ex_rf_we = 1; ex_rd = 4'd9; id_rn = 4'd9; id_use_rn = 1;
    settle();
    checks++; if (ctl !== C_LSTALL) begin errors++; $display("FAIL nds_first: got %b want %b", ctl, C_LSTALL); end
    next_cycle();
    settle();
    checks++; if (ctl !== C_RUN) begin errors++; $display("FAIL nds_second: got %b want %b", ctl, C_RUN); end
    next_cycle();
    clear_inputs();
    settle();
    checks++; if (seq_state !== 2'b00) begin errors++; $display("FAIL nds_state: got %b want 00", seq_state); end
  endtask

  task automatic test_branch_vs_load();
    next_cycle();
    clear_inputs();
    ex_branch_taken = 1;
    ex_is_load = 1; ex_rf_we = 1; ex_rd = 4'd4; id_rn = 4'd4; id_use_rn = 1;
    settle();
    checks++; if (ctl !== C_BRANCH) begin errors++; $display("FAIL br_lu_ctl: got %b want %b", ctl, C_BRANCH); end
    next_cycle();
    clear_inputs();
    settle();
    checks++; if (seq_state !== 2'b11) begin errors++; $display("FAIL br_flush_state: got %b want 11", seq_state); end
    checks++; if (ctl !== C_FLUSH) begin errors++; $display("FAIL br_flush_ctl: got %b want %b", ctl, C_FLUSH); end
    next_cycle();
    settle();
    checks++; if (seq_state !== 2'b00) begin errors++; $display("FAIL br_back_to_run: got %b want 00", seq_state); end
    checks++; if (ctl !== C_RUN) begin errors++; $display("FAIL br_run_ctl: got %b want %b", ctl, C_RUN); end
  endtask

  task automatic test_mem_wait_branch();
    logic [1:0] exp_state [3] = '{2'b00, 2'b10, 2'b10};
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      clear_inputs();
      mem_busy = 1; ex_branch_taken = 1;
      settle();
      checks++; if (ctl !== C_HOLD) begin errors++; $display("FAIL mw_hold[%0d]: got %b want %b", i, ctl, C_HOLD); end
      checks++; if (seq_state !== exp_state[i]) begin errors++; $display("FAIL mw_state[%0d]: got %b want %b", i, seq_state, exp_state[i]); end
    end
    next_cycle();
    mem_busy = 0;
    settle();
    checks++; if (ctl !== C_BRANCH) begin errors++; $display("FAIL mw_release_branch: got %b want %b", ctl, C_BRANCH); end
    next_cycle();
    clear_inputs();
    settle();
    checks++; if (seq_state !== 2'b11) begin errors++; $display("FAIL mw_flush_state: got %b want 11", seq_state); end
  endtask

  task automatic test_reset_in_mem_wait();
    next_cycle();
    clear_inputs();
    reset = 1;
    next_cycle();
    reset = 0; mem_busy = 1;
    next_cycle();
    settle();
    checks++; if (seq_state !== 2'b10) begin errors++; $display("FAIL rmw_wait_state: got %b want 10", seq_state); end
    next_cycle();
`ifdef PIPELINE_SEQ_PERF_EN
    checks++; if (stall_count !== 16'd2) begin errors++; $display("FAIL rmw_count_before: got %0d want 2", stall_count); end
`endif
    reset = 1;
    settle();
    checks++; if (ctl !== C_RESET) begin errors++; $display("FAIL rmw_reset_ctl: got %b want %b", ctl, C_RESET); end
    next_cycle();
    reset = 0; mem_busy = 0;
    settle();
    checks++; if (seq_state !== 2'b00) begin errors++; $display("FAIL rmw_after_state: got %b want 00", seq_state); end
    checks++; if (ctl !== C_RUN) begin errors++; $display("FAIL rmw_after_ctl: got %b want %b", ctl, C_RUN); end
`ifdef PIPELINE_SEQ_PERF_EN
    checks++; if (stall_count !== 16'd0) begin errors++; $display("FAIL rmw_count_cleared: got %0d want 0", stall_count); end
`endif
  endtask

  initial begin
    clear_inputs();
    reset = 1;
    test_reset();
    test_forward_ex();
    test_forward_priority();
    test_r15();
    test_load_use();
    test_no_double_stall();
    test_branch_vs_load();
    test_mem_wait_branch();
    test_reset_in_mem_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
